// File: rtl/alu_exec_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_seq
// Purpose  : Multi-cycle execute stage. Decodes opcode/funct3/funct7, selects
//            operands, computes base ALU results and branch conditions in one
//            cycle, and runs RV32M multiply/divide on an iterative XLEN-step
//            shift-add / restoring-divide engine.
// Ports    : clk_i, rst_ni          clock, async active-low reset
//            valid_i / ready_o      request handshake (accept = valid_i & ready_o)
//            op_i, funct3_i, funct7_i, rs1_i, rs2_i, imm_i, pc_i  request fields
//            valid_o / ready_i      result handshake
//            result_o, alu_sel_o, taken_o, illegal_o               result fields
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_seq #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [6:0]      op_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      alu_sel_o,
    output logic            taken_o,
    output logic            illegal_o
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [6:0] c_OP_LOAD   = 7'd3;
    localparam logic [6:0] c_OP_IMM    = 7'd19;
    localparam logic [6:0] c_OP_AUIPC  = 7'd23;
    localparam logic [6:0] c_OP_STORE  = 7'd35;
    localparam logic [6:0] c_OP_REG    = 7'd51;
    localparam logic [6:0] c_OP_LUI    = 7'd55;
    localparam logic [6:0] c_OP_BRANCH = 7'd99;
    localparam logic [6:0] c_OP_JALR   = 7'd103;
    localparam logic [6:0] c_OP_JAL    = 7'd111;

    localparam logic [6:0] c_F7_BASE = 7'h00;
    localparam logic [6:0] c_F7_ALT  = 7'h20;
    localparam logic [6:0] c_F7_M    = 7'h01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Base ALU
    // ------------------------------------------------------------------
    function automatic logic [XLEN-1:0] f_alu(input logic [4:0] sel,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [XLEN-1:0] y;
        case (sel)
            5'd0:    y = a + b;
            5'd1:    y = a - b;
            5'd2:    y = a << b[SHW-1:0];
            5'd3:    y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            5'd4:    y = {{(XLEN-1){1'b0}}, (a < b)};
            5'd5:    y = a ^ b;
            5'd6:    y = a >> b[SHW-1:0];
            5'd7:    y = $signed(a) >>> b[SHW-1:0];
            5'd8:    y = a | b;
            5'd9:    y = a & b;
            default: y = '0;
        endcase
        return y;
    endfunction

    // funct3 to base ALU code; alt selects sub (funct3 0) or sra (funct3 5)
    function automatic logic [4:0] f_base_sel(input logic [2:0] f3, input logic alt);
        logic [4:0] s;
        case (f3)
            3'd0:    s = alt ? 5'd1 : 5'd0;
            3'd1:    s = 5'd2;
            3'd2:    s = 5'd3;
            3'd3:    s = 5'd4;
            3'd4:    s = 5'd5;
            3'd5:    s = alt ? 5'd7 : 5'd6;
            3'd6:    s = 5'd8;
            default: s = 5'd9;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_next;
    logic [SHW-1:0]      r_cnt;
    logic [2*XLEN-1:0]   r_acc;     // mul: {partial hi, multiplier}; div: {rem, quotient}
    logic [XLEN-1:0]     r_b;       // multiplicand or divisor magnitude
    logic                r_neg;     // negate product / quotient
    logic                r_neg_rem; // negate remainder (dividend was negative)
    logic [2:0]          r_mf3;
    logic                r_valid;
    logic [XLEN-1:0]     r_result;
    logic [4:0]          r_alu_sel;
    logic                r_taken;
    logic                r_illegal;

    // ------------------------------------------------------------------
    // Decode and single-cycle datapath
    // ------------------------------------------------------------------
    logic [4:0]      w_sel;
    logic [XLEN-1:0] w_opa;
    logic [XLEN-1:0] w_opb;
    logic            w_illegal;
    logic            w_is_m;
    logic            w_is_jump;
    logic            w_is_branch;

    always_comb begin
        w_sel       = 5'd0;
        w_opa       = rs1_i;
        w_opb       = rs2_i;
        w_illegal   = 1'b0;
        w_is_m      = 1'b0;
        w_is_jump   = 1'b0;
        w_is_branch = 1'b0;
        case (op_i)
            c_OP_LOAD, c_OP_STORE: w_opb = imm_i;
            c_OP_IMM: begin
                w_opb = imm_i;
                w_sel = f_base_sel(funct3_i, (funct3_i == 3'd5) && (funct7_i == c_F7_ALT));
                if (funct3_i == 3'd1 && funct7_i != c_F7_BASE)
                    w_illegal = 1'b1;
                if (funct3_i == 3'd5 && funct7_i != c_F7_BASE && funct7_i != c_F7_ALT)
                    w_illegal = 1'b1;
            end
            c_OP_AUIPC: begin
                w_opa = pc_i;
                w_opb = imm_i;
            end
            c_OP_LUI: begin
                w_opa = '0;
                w_opb = imm_i;
            end
            c_OP_REG: begin
                if (funct7_i == c_F7_BASE) begin
                    w_sel = f_base_sel(funct3_i, 1'b0);
                end else if (funct7_i == c_F7_ALT &&
                             (funct3_i == 3'd0 || funct3_i == 3'd5)) begin
                    w_sel = f_base_sel(funct3_i, 1'b1);
                end else if (funct7_i == c_F7_M && ENABLE_M) begin
                    w_is_m = 1'b1;
                    w_sel  = {2'b10, funct3_i};
                end else begin
                    w_illegal = 1'b1;
                end
            end
            c_OP_BRANCH: begin
                w_is_branch = 1'b1;
                case (funct3_i)
                    3'd0, 3'd1: w_sel = 5'd1;
                    3'd4, 3'd5: w_sel = 5'd3;
                    3'd6, 3'd7: w_sel = 5'd4;
                    default:    w_illegal = 1'b1;
                endcase
            end
            c_OP_JAL, c_OP_JALR: w_is_jump = 1'b1;
            default: w_illegal = 1'b1;
        endcase
    end

    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_res_single;
    logic            w_taken;

    assign w_alu = f_alu(w_sel, w_opa, w_opb);

    always_comb begin
        w_res_single = w_alu;
        if (w_illegal)
            w_res_single = '0;
        else if (w_is_jump)
            w_res_single = pc_i + XLEN'(4);
    end

    // Even funct3 tests the raw condition, odd funct3 its complement.
    always_comb begin
        w_taken = 1'b0;
        if (w_is_branch && !w_illegal) begin
            if (funct3_i[2])
                w_taken = w_alu[0] ^ funct3_i[0];
            else
                w_taken = (w_alu == '0) ^ funct3_i[0];
        end
    end

    // ------------------------------------------------------------------
    // M-extension operand preparation and special divide cases
    // ------------------------------------------------------------------
    logic            w_sa;
    logic            w_sb;
    logic            w_na;
    logic            w_nb;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;
    logic            w_single;

    // div/rem are signed; mulh signs both operands, mulhsu only rs1
    assign w_sa = funct3_i[2] ? ~funct3_i[0] : (funct3_i[1:0] == 2'd1 || funct3_i[1:0] == 2'd2);
    assign w_sb = funct3_i[2] ? ~funct3_i[0] : (funct3_i[1:0] == 2'd1);
    assign w_na = w_sa & rs1_i[XLEN-1];
    assign w_nb = w_sb & rs2_i[XLEN-1];
    assign w_mag_a = w_na ? (~rs1_i + XLEN'(1)) : rs1_i;
    assign w_mag_b = w_nb ? (~rs2_i + XLEN'(1)) : rs2_i;

    assign w_div_zero = funct3_i[2] && (rs2_i == '0);
    assign w_div_ovf  = funct3_i[2] && !funct3_i[0] &&
                        (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
    assign w_special  = w_is_m && (w_div_zero || w_div_ovf);

    always_comb begin
        if (w_div_zero)
            w_special_res = funct3_i[1] ? rs1_i : '1;
        else
            w_special_res = funct3_i[1] ? '0 : rs1_i;
    end

    assign w_single = !w_is_m || w_special;

    // ------------------------------------------------------------------
    // Iterative engine step
    // ------------------------------------------------------------------
    logic [XLEN:0]     w_mul_hi;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_div_sh;
    logic [XLEN:0]     w_div_diff;
    logic              w_div_ge;
    logic [2*XLEN-1:0] w_div_next;
    logic [2*XLEN-1:0] w_acc_next;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_m_final;

    // Right-shifting shift-add: add multiplicand into the high half when the
    // current multiplier bit (acc LSB) is set, then shift the whole thing down.
    assign w_mul_hi   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_next = {w_mul_hi, r_acc[XLEN-1:1]};

    // Restoring divide: shift next dividend bit into the remainder, subtract.
    assign w_div_sh   = r_acc[2*XLEN-1:XLEN-1];
    assign w_div_diff = w_div_sh - {1'b0, r_b};
    assign w_div_ge   = ~w_div_diff[XLEN];
    assign w_div_next = {(w_div_ge ? w_div_diff[XLEN-1:0] : w_div_sh[XLEN-1:0]),
                         r_acc[XLEN-2:0], w_div_ge};

    assign w_acc_next = (r_state == S_DIV) ? w_div_next : w_mul_next;

    assign w_prod = r_neg ? (~w_acc_next + (2*XLEN)'(1)) : w_acc_next;
    assign w_quo  = r_neg ? (~w_acc_next[XLEN-1:0] + XLEN'(1)) : w_acc_next[XLEN-1:0];
    assign w_rem  = r_neg_rem ? (~w_acc_next[2*XLEN-1:XLEN] + XLEN'(1))
                              : w_acc_next[2*XLEN-1:XLEN];

    always_comb begin
        if (r_state == S_DIV)
            w_m_final = r_mf3[1] ? w_rem : w_quo;
        else
            w_m_final = (r_mf3 == 3'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    logic   w_accept;
    state_t w_accept_state;

    assign ready_o        = (r_state == S_IDLE) || ((r_state == S_DONE) && ready_i);
    assign w_accept       = valid_i && ready_o;
    assign w_accept_state = w_single ? S_DONE : (funct3_i[2] ? S_DIV : S_MUL);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_state_next = w_accept_state;
            end
            S_MUL, S_DIV: begin
                if (r_cnt == '0)
                    w_state_next = S_DONE;
            end
            default: begin
                if (w_accept)
                    w_state_next = w_accept_state;
                else if (ready_i)
                    w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_b       <= '0;
            r_neg     <= 1'b0;
            r_neg_rem <= 1'b0;
            r_mf3     <= 3'd0;
            r_valid   <= 1'b0;
            r_result  <= '0;
            r_alu_sel <= 5'd0;
            r_taken   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_valid <= w_single;
            if (w_single) begin
                r_result  <= w_is_m ? w_special_res : w_res_single;
                r_alu_sel <= w_illegal ? 5'd0 : w_sel;
                r_taken   <= w_taken;
                r_illegal <= w_illegal;
            end else begin
                r_cnt     <= SHW'(XLEN-1);
                r_mf3     <= funct3_i;
                r_neg     <= w_na ^ w_nb;
                r_neg_rem <= w_na;
                if (funct3_i[2]) begin
                    r_acc <= {{XLEN{1'b0}}, w_mag_a};
                    r_b   <= w_mag_b;
                end else begin
                    r_acc <= {{XLEN{1'b0}}, w_mag_b};
                    r_b   <= w_mag_a;
                end
            end
        end else begin
            case (r_state)
                S_MUL, S_DIV: begin
                    r_acc <= w_acc_next;
                    if (r_cnt == '0) begin
                        r_valid   <= 1'b1;
                        r_result  <= w_m_final;
                        r_alu_sel <= {2'b10, r_mf3};
                        r_taken   <= 1'b0;
                        r_illegal <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - SHW'(1);
                    end
                end
                S_DONE: begin
                    if (ready_i)
                        r_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign valid_o   = r_valid;
    assign result_o  = r_result;
    assign alu_sel_o = r_alu_sel;
    assign taken_o   = r_taken;
    assign illegal_o = r_illegal;

endmodule
`default_nettype wire
